// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for a 4-digit multiplexed seven-segment display.
// Ownership changes only at frame boundaries; the arbiter runs the scan itself.
module seg_display_arbiter #(
    parameter int SCAN_DIV   = 100000,
    parameter int MIN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [3:0]  dp0,
    input  logic [3:0]  dp1,
    input  logic [3:0]  blank0,
    input  logic [3:0]  blank1,
    output logic [1:0]  gnt,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(MIN_FRAMES + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic [DW-1:0] div_cnt;
    logic [1:0]    d;
    logic [HW-1:0] held;
    logic [15:0]   s_val;
    logic [3:0]    s_dp;
    logic [3:0]    s_blank;

    logic          tick;
    logic          boundary;
    logic          other;
    logic          win;
    logic          sw;
    logic          load_sel;
    logic [HW-1:0] held_next;
    logic          lit;
    logic [3:0]    nib;
    logic [3:0]    an_next;
    logic [7:0]    seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001101;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        tick      = (div_cnt == DW'(SCAN_DIV - 1));
        boundary  = (state == OWN) && tick && (d == 2'd3);
        other     = ~owner;
        win       = (req == 2'b11) ? ~last_owner : req[1];
        held_next = (held == HW'(MIN_FRAMES)) ? held : held + 1'b1;
        // A waiting requester takes over when the owner leaves or its hold expires.
        sw        = req[other] &&
                    (!req[owner] || held_next == HW'(MIN_FRAMES));
        load_sel  = (state == IDLE) ? win : (sw ? other : owner);
        lit       = (state == OWN) && !s_blank[d];
        nib       = s_val[{d, 2'b00} +: 4];
        an_next   = lit ? ~(4'b0001 << d) : 4'b1111;
        seg_next  = lit ? {hex7(nib), ~s_dp[d]} : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            div_cnt    <= '0;
            d          <= 2'd0;
            held       <= '0;
            s_val      <= '0;
            s_dp       <= '0;
            s_blank    <= '0;
            gnt        <= 2'b00;
            frame_done <= 1'b0;
            an         <= 4'b1111;
            seg        <= 8'hFF;
        end else begin
            frame_done <= 1'b0;
            an         <= an_next;
            seg        <= seg_next;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= OWN;
                        owner   <= win;
                        gnt     <= win ? 2'b10 : 2'b01;
                        div_cnt <= '0;
                        d       <= 2'd0;
                        held    <= '0;
                        s_val   <= load_sel ? val1 : val0;
                        s_dp    <= load_sel ? dp1 : dp0;
                        s_blank <= load_sel ? blank1 : blank0;
                    end
                end
                default: begin
                    if (tick) begin
                        div_cnt <= '0;
                        d       <= d + 2'd1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (boundary) begin
                        frame_done <= 1'b1;
                        if (sw) begin
                            owner      <= other;
                            last_owner <= owner;
                            gnt        <= other ? 2'b10 : 2'b01;
                            held       <= '0;
                        end else if (!req[owner]) begin
                            state      <= IDLE;
                            gnt        <= 2'b00;
                            last_owner <= owner;
                        end else begin
                            held <= held_next;
                        end
                        s_val   <= load_sel ? val1 : val0;
                        s_dp    <= load_sel ? dp1 : dp0;
                        s_blank <= load_sel ? blank1 : blank0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed vectors plus
// randomized traffic against a frame-level reference model.
module tb_seg_display_arbiter;

    localparam int SD    = 4;
    localparam int MF    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] val0, val1;
    logic [3:0]  dp0, dp1, blank0, blank1;
    logic [1:0]  gnt;
    logic        frame_done;
    logic [3:0]  an;
    logic [7:0]  seg;

    seg_display_arbiter #(.SCAN_DIV(SD), .MIN_FRAMES(MF)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .val0(val0), .val1(val1), .dp0(dp0), .dp1(dp1),
        .blank0(blank0), .blank1(blank1),
        .gnt(gnt), .frame_done(frame_done), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] hex_tab [16];

    int          m_own, m_p, m_held, m_last;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_bl;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic [1:0]  e_gnt;
    logic        e_fd;

    typedef struct {
        logic [1:0]  rq;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [3:0]  d1;
        logic [3:0]  b1;
        int          n;
        logic [3:0]  x_an;
        logic [7:0]  x_seg;
        logic [1:0]  x_gnt;
        logic        x_fd;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_own  = -1;
        m_p    = 0;
        m_held = 0;
        m_last = 1;
        m_val  = '0;
        m_dp   = '0;
        m_bl   = '0;
        e_an   = 4'hF;
        e_seg  = 8'hFF;
        e_gnt  = 2'b00;
        e_fd   = 1'b0;
    endtask

    task automatic mdl_load(input int who);
        m_val = (who == 1) ? val1 : val0;
        m_dp  = (who == 1) ? dp1 : dp0;
        m_bl  = (who == 1) ? blank1 : blank0;
    endtask

    task automatic mdl_switch(input int from);
        m_last = from;
        m_own  = 1 - from;
        m_held = 0;
        mdl_load(1 - from);
    endtask

    task automatic mdl_step();
        int dig, o, oth, hn, w;
        if (m_own < 0) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end else begin
            dig = m_p / SD;
            if (m_bl[dig]) begin
                e_an  = 4'hF;
                e_seg = 8'hFF;
            end else begin
                e_an  = ~(4'b0001 << dig);
                e_seg = {hex_tab[m_val[dig*4 +: 4]], ~m_dp[dig]};
            end
        end
        e_fd = 1'b0;
        if (m_own < 0) begin
            if (req != 2'b00) begin
                w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                m_own  = w;
                m_p    = 0;
                m_held = 0;
                mdl_load(w);
            end
        end else if (m_p == FRAME - 1) begin
            e_fd = 1'b1;
            m_p  = 0;
            o    = m_own;
            oth  = 1 - o;
            hn   = (m_held + 1 > MF) ? MF : m_held + 1;
            if (!req[o] && req[oth]) mdl_switch(o);
            else if (!req[o]) begin
                m_last = o;
                m_own  = -1;
            end else if (req[oth] && hn == MF) mdl_switch(o);
            else begin
                m_held = hn;
                mdl_load(o);
            end
        end else begin
            m_p++;
        end
        e_gnt = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
    endtask

    task automatic cycle(input bit chk);
        @(posedge clk);
        if (!rst_n) mdl_reset();
        else mdl_step();
        @(negedge clk);
        if (chk)
            check("model", {17'd0, an, seg, gnt, frame_done},
                  {17'd0, e_an, e_seg, e_gnt, e_fd});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mdl_reset();
        cycle(0);
        cycle(0);
        rst_n = 1'b1;
    endtask

    initial begin
        hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        tv.push_back('{2'b01, 16'h1234, 16'h0, 4'h0, 4'h0,  1, 4'hF, 8'hFF, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'h1234, 16'h0, 4'h0, 4'h0,  1, 4'hE, 8'h99, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'h1234, 16'h0, 4'h0, 4'h0,  3, 4'hE, 8'h99, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'h1234, 16'h0, 4'h0, 4'h0,  1, 4'hD, 8'h0D, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  3, 4'hD, 8'h0D, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  1, 4'hB, 8'h25, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  4, 4'h7, 8'h9F, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  3, 4'h7, 8'h9F, 2'b01, 1'b1});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  1, 4'hE, 8'h85, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  4, 4'hD, 8'h63, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  4, 4'hB, 8'hC1, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0,  4, 4'h7, 8'h11, 2'b01, 1'b0});
        tv.push_back('{2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0, 12, 4'hB, 8'hC1, 2'b01, 1'b0});
        tv.push_back('{2'b00, 16'hABCD, 16'h0, 4'h0, 4'h0,  4, 4'h7, 8'h11, 2'b01, 1'b0});
        tv.push_back('{2'b00, 16'hABCD, 16'h0, 4'h0, 4'h0,  3, 4'h7, 8'h11, 2'b00, 1'b1});
        tv.push_back('{2'b00, 16'hABCD, 16'h0, 4'h0, 4'h0,  1, 4'hF, 8'hFF, 2'b00, 1'b0});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  1, 4'hF, 8'hFF, 2'b10, 1'b0});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  1, 4'hE, 8'h02, 2'b10, 1'b0});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  4, 4'hF, 8'hFF, 2'b10, 1'b0});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  4, 4'hB, 8'h03, 2'b10, 1'b0});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  4, 4'hF, 8'hFF, 2'b10, 1'b0});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  3, 4'hF, 8'hFF, 2'b10, 1'b1});
        tv.push_back('{2'b10, 16'hABCD, 16'h0, 4'h1, 4'hA,  1, 4'hE, 8'h02, 2'b10, 1'b0});

        // Reset held with both requesting.
        rst_n  = 1'b0;
        req    = 2'b11;
        val0   = 16'h5A5A;
        val1   = 16'hA5A5;
        dp0    = 4'h0;
        dp1    = 4'h0;
        blank0 = 4'h0;
        blank1 = 4'h0;
        mdl_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(0);
            check("reset_an", {28'd0, an}, 32'hF);
            check("reset_seg", {24'd0, seg}, 32'hFF);
            check("reset_gnt", {30'd0, gnt}, 32'h0);
        end
        req   = 2'b00;
        val0  = 16'h0;
        val1  = 16'h0;
        rst_n = 1'b1;
        cycle(1);

        // Directed single-owner, mid-frame change, drop and blank/dp vectors.
        for (int i = 0; i < tv.size(); i++) begin
            req    = tv[i].rq;
            val0   = tv[i].v0;
            dp0    = 4'h0;
            blank0 = 4'h0;
            val1   = tv[i].v1;
            dp1    = tv[i].d1;
            blank1 = tv[i].b1;
            for (int c = 0; c < tv[i].n; c++) cycle(1);
            check($sformatf("vec%0d_an", i), {28'd0, an}, {28'd0, tv[i].x_an});
            check($sformatf("vec%0d_seg", i), {24'd0, seg}, {24'd0, tv[i].x_seg});
            check($sformatf("vec%0d_gnt", i), {30'd0, gnt}, {30'd0, tv[i].x_gnt});
            check($sformatf("vec%0d_fd", i), {31'd0, frame_done}, {31'd0, tv[i].x_fd});
        end

        // Contention from reset: 0 first, hold 2 frames, alternate.
        do_reset();
        req    = 2'b11;
        val0   = 16'h1111;
        val1   = 16'h2222;
        dp1    = 4'h0;
        blank1 = 4'h0;
        for (int k = 1; k <= 70; k++) begin
            cycle(1);
            check($sformatf("cont_gnt_%0d", k), {30'd0, gnt},
                  (k < 2 * FRAME + 1) ? 32'h1 : ((k < 4 * FRAME + 1) ? 32'h2 : 32'h1));
            check($sformatf("cont_fd_%0d", k), {31'd0, frame_done},
                  (k > 1 && (k - 1) % FRAME == 0) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset mid-frame.
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check("async_an", {28'd0, an}, 32'hF);
        check("async_seg", {24'd0, seg}, 32'hFF);
        check("async_gnt", {30'd0, gnt}, 32'h0);
        check("async_fd", {31'd0, frame_done}, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1);
        rst_n = 1'b1;
        cycle(1);
        check("restart_gnt", {30'd0, gnt}, 32'h1);

        // Randomized traffic against the model.
        do_reset();
        req = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                val0   = 16'($urandom);
                val1   = 16'($urandom);
                dp0    = 4'($urandom);
                dp1    = 4'($urandom);
                blank0 = 4'($urandom);
                blank1 = 4'($urandom);
            end
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
